// File: rtl/debounce_filter.sv
// Two-flop synchroniser plus four-state stability qualifier for a bouncing
// level input; db_out only moves once the new level has held long enough.
module debounce_filter #(
  parameter int unsigned DEBOUNCE_CNT = 500000,
  parameter int unsigned CNT_W        = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic db_out,
  output logic settling
);

  typedef enum logic [1:0] {
    S_LO,
    WAIT_HI,
    S_HI,
    WAIT_LO
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic             sync1_q;
  logic             sync2_q;
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             db_q;
  logic             db_d;
  logic             settling_q;
  logic             settling_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      state_q    <= S_LO;
      cnt_q      <= '0;
      db_q       <= 1'b0;
      settling_q <= 1'b0;
    end else begin
      sync1_q    <= raw_in;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      db_q       <= db_d;
      settling_q <= settling_d;
    end
  end

  // An opposite sample during a WAIT state drops all accumulated credit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_LO: begin
        if (sync2_q) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!sync2_q) begin
          state_d = S_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HI: begin
        if (!sync2_q) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (sync2_q) begin
          state_d = S_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered copies of the next-state decode.
  always_comb begin
    db_d       = (state_d == S_HI) || (state_d == WAIT_LO);
    settling_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
  end

  assign db_out   = db_q;
  assign settling = settling_q;

endmodule

// File: tb/tb_debounce_filter.sv
// Scoreboard bench: two debounce_filter instances (DEBOUNCE_CNT 4 and 1)
// share stimulus and are checked against a run-length reference model.
module tb_debounce_filter;

  logic clk;
  logic reset;
  logic raw_in;
  logic db4;
  logic set4;
  logic db1;
  logic set1;

  int checks = 0;
  int errors = 0;

  debounce_filter #(
    .DEBOUNCE_CNT(4),
    .CNT_W       (3)
  ) u_dut4 (
    .clk     (clk),
    .reset   (reset),
    .raw_in  (raw_in),
    .db_out  (db4),
    .settling(set4)
  );

  debounce_filter #(
    .DEBOUNCE_CNT(1),
    .CNT_W       (1)
  ) u_dut1 (
    .clk     (clk),
    .reset   (reset),
    .raw_in  (raw_in),
    .db_out  (db1),
    .settling(set1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the FSM sees raw_in two edges late; db flips after
  // D+1 consecutive samples that differ from it.
  int unsigned dcnt [2] = '{4, 1};
  bit          m_s1;
  bit          m_s2;
  int          m_run [2];
  bit          m_db  [2];
  bit    [1:0] q4 [$];
  bit    [1:0] q1 [$];

  task automatic model_edge(input bit rst, input bit r);
    bit smp;
    if (rst) begin
      m_s1 = 0;
      m_s2 = 0;
      for (int k = 0; k < 2; k++) begin
        m_run[k] = 0;
        m_db[k]  = 0;
      end
    end else begin
      smp  = m_s2;
      m_s2 = m_s1;
      m_s1 = r;
      for (int k = 0; k < 2; k++) begin
        if (smp != m_db[k]) begin
          m_run[k]++;
          if (m_run[k] == int'(dcnt[k]) + 1) begin
            m_db[k]  = ~m_db[k];
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
    end
    q4.push_back({m_db[0], m_run[0] > 0});
    q1.push_back({m_db[1], m_run[1] > 0});
  endtask

  task automatic step(input bit rst, input bit r);
    reset  = rst;
    raw_in = r;
    @(posedge clk);
    model_edge(rst, r);
    @(negedge clk);
  endtask

  task automatic hold(input bit r, input int n);
    for (int i = 0; i < n; i++) step(1'b0, r);
  endtask

  task automatic cmp(input string nm, input bit act, input bit exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  always @(negedge clk) begin
    bit [1:0] e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      cmp("db_out_d4", db4, e[1]);
      cmp("settling_d4", set4, e[0]);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp("db_out_d1", db1, e[1]);
      cmp("settling_d1", set1, e[0]);
    end
  end

  initial begin
    bit          lvl;
    int unsigned len;
    reset  = 1'b1;
    raw_in = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    // clean rise then clean fall
    hold(1'b1, 12);
    hold(1'b0, 12);
    // short high pulse rejected
    hold(1'b1, 3);
    hold(1'b0, 10);
    // bounce then settle high
    hold(1'b1, 1); hold(1'b0, 1);
    hold(1'b1, 2); hold(1'b0, 1);
    hold(1'b1, 12);
    // brief low dip while high, then real fall
    hold(1'b0, 2);
    hold(1'b1, 8);
    hold(1'b0, 12);
    // reset during qualification, raw_in held high through it
    hold(1'b1, 5);
    step(1'b1, 1'b1);
    hold(1'b1, 10);
    hold(1'b0, 10);
    // single-cycle glitch
    hold(1'b1, 1);
    hold(1'b0, 8);
    // randomized holds with occasional reset
    lvl = 1'b0;
    for (int i = 0; i < 600; i++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 40) == 0) step(1'b1, lvl);
      hold(lvl, int'(len));
    end
    @(negedge clk);
    checks++;
    if (q4.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending expected 0", q4.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
